// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// HAZARD_PERF_EN (see hazard_unit) adds saturating performance counters.
package hazard_pkg;

  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
  localparam int unsigned CNT_WIDTH_DEF      = 32;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic {
    StRun,
    StMiss
  } state_e;

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side signal bundle for the hazard unit: stage register indices and
// control in, forwarding selects and stall/flush controls out.
interface hazard_if #(
    parameter int unsigned REG_ADDR_WIDTH = hazard_pkg::REG_ADDR_WIDTH_DEF
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic                      RegWriteM, RegWriteW;
    logic                      ResultSrcE0;
    logic                      PCSrcE;
    logic                      MemAccessM, CacheHitM, CacheReadyM;
    logic [1:0]                ForwardAE, ForwardBE;
    logic                      StallF, StallD, StallE, StallM;
    logic                      FlushD, FlushE, FlushW;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
        output MemAccessM, CacheHitM, CacheReadyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
        input  MemAccessM, CacheHitM, CacheReadyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW
    );
endinterface

// File: rtl/hazard_unit_forward_select.sv
// Operand forward select for one E-stage source register; M beats W, x0 never
// forwarded.
module forward_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
    input  logic                      reg_write_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
    input  logic                      reg_write_w_i,
    output logic [1:0]                fwd_o
);

    always_comb begin
        fwd_o = FWD_REG;
        if (reg_write_m_i && (rd_m_i == rs_i) && (rd_m_i != '0)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i == rs_i) && (rd_w_i != '0)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and D-cache
// miss stall FSM. Define HAZARD_PERF_EN to add saturating perf counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_if.slave              hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] StallCycles,
    output logic [CNT_WIDTH-1:0] LoadUseCount,
    output logic [CNT_WIDTH-1:0] MissCount
`endif
);

    state_e state_q, state_d;
    logic   lw_stall, miss_now, mem_stall;

    forward_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs_i          (hz.Rs1E),
        .rd_m_i        (hz.RdM),
        .reg_write_m_i (hz.RegWriteM),
        .rd_w_i        (hz.RdW),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_o         (hz.ForwardAE)
    );

    forward_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs_i          (hz.Rs2E),
        .rd_m_i        (hz.RdM),
        .reg_write_m_i (hz.RegWriteM),
        .rd_w_i        (hz.RdW),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_o         (hz.ForwardBE)
    );

    assign lw_stall = hz.ResultSrcE0 && (hz.RdE != '0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign miss_now = hz.MemAccessM && !hz.CacheHitM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StRun;
        else        state_q <= state_d;
    end

    // The refill-complete cycle is not a stall, so the pipeline advances on that edge.
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        unique case (state_q)
            StRun: begin
                mem_stall = miss_now;
                if (miss_now) state_d = StMiss;
            end
            StMiss: begin
                mem_stall = !hz.CacheReadyM;
                if (hz.CacheReadyM) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // A memory stall freezes everything and masks branch/load-use flushes.
    always_comb begin
        hz.StallF = lw_stall;
        hz.StallD = lw_stall;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = hz.PCSrcE;
        hz.FlushE = lw_stall || hz.PCSrcE;
        hz.FlushW = 1'b0;
        if (mem_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushD = 1'b0;
            hz.FlushE = 1'b0;
            hz.FlushW = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, lu_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (mem_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (lw_stall && (lu_cnt_q != '1))     lu_cnt_q    <= lu_cnt_q + 1'b1;
            if ((state_q == StRun) && miss_now && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign StallCycles  = stall_cnt_q;
    assign LoadUseCount = lu_cnt_q;
    assign MissCount    = miss_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// against a behavioural model. Counter checks compile in with HAZARD_PERF_EN.
module tb_hazard_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hazard_if #(.REG_ADDR_WIDTH(AW)) hz ();

`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cycles, load_use_count, miss_count;
`endif

    hazard_unit #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
`ifdef HAZARD_PERF_EN
        ,
        .StallCycles  (stall_cycles),
        .LoadUseCount (load_use_count),
        .MissCount    (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: "waiting for a refill" flag plus event tallies.
    bit          m_miss;
    int unsigned m_stall_cnt, m_lu_cnt, m_miss_cnt;

    function automatic logic [1:0] fwd_ref(logic [AW-1:0] rs, logic [AW-1:0] rdm, bit wm,
                                           logic [AW-1:0] rdw, bit ww);
        if (wm && rdm == rs && rdm != 0) return 2'b10;
        if (ww && rdw == rs && rdw != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit lw_ref();
        return hz.ResultSrcE0 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    endfunction

    function automatic bit mem_stall_ref();
        bit mn;
        mn = hz.MemAccessM && !hz.CacheHitM;
        return m_miss ? !hz.CacheReadyM : mn;
    endfunction

    // {FA, FB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    function automatic logic [10:0] exp_out();
        logic [1:0] fa, fb;
        bit         lw, ms, pc;
        fa = fwd_ref(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        fb = fwd_ref(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        lw = lw_ref();
        ms = mem_stall_ref();
        pc = hz.PCSrcE;
        if (ms) return {fa, fb, 7'b1111001};
        return {fa, fb, lw, lw, 1'b0, 1'b0, pc, lw | pc, 1'b0};
    endfunction

    function automatic logic [10:0] act_out();
        return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW};
    endfunction

    task automatic clear_inputs();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE0 = 1'b0;
        hz.PCSrcE = 1'b0; hz.MemAccessM = 1'b0; hz.CacheHitM = 1'b0; hz.CacheReadyM = 1'b0;
    endtask

    // Advance one rising edge, updating the model from the pre-edge inputs.
    task automatic clock_step();
        bit mn, ms, lw;
        mn = hz.MemAccessM && !hz.CacheHitM;
        ms = mem_stall_ref();
        lw = lw_ref();
        @(posedge clk);
        if (rst_n) begin
            if (ms) m_stall_cnt++;
            if (lw) m_lu_cnt++;
            if (!m_miss && mn) m_miss_cnt++;
            m_miss = m_miss ? !hz.CacheReadyM : mn;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_miss = 1'b0;
        m_stall_cnt = 0; m_lu_cnt = 0; m_miss_cnt = 0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m_miss = 1'b0;
        m_stall_cnt = 0; m_lu_cnt = 0; m_miss_cnt = 0;
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (act_out() !== 11'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected %b", act_out(), 11'b0);
        end
`ifdef HAZARD_PERF_EN
        n_vec++;
        if ({stall_cycles, load_use_count, miss_count} !== '0) begin
            n_err++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                     stall_cycles, load_use_count, miss_count);
        end
`endif
        rst_n = 1'b1;
        clock_step();
    endtask

    task automatic test_forward();
        clear_inputs();
        hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1;
        #1;
        n_vec++;
        if (hz.ForwardAE !== 2'b10) begin
            n_err++;
            $display("FAIL fwd_m_priority: got %b expected 10", hz.ForwardAE);
        end
        hz.RegWriteM = 0;
        #1;
        n_vec++;
        if (hz.ForwardAE !== 2'b01) begin
            n_err++;
            $display("FAIL fwd_w: got %b expected 01", hz.ForwardAE);
        end
        clear_inputs();
        hz.RdM = 0; hz.RegWriteM = 1; hz.Rs2E = 0; hz.RegWriteW = 1;
        #1;
        n_vec++;
        if (hz.ForwardBE !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_x0: got %b expected 00", hz.ForwardBE);
        end
        hz.Rs2E = 9; hz.RdM = 9; hz.RdW = 9;
        #1;
        n_vec++;
        if (act_out() !== exp_out()) begin
            n_err++;
            $display("FAIL fwd_b_m: got %b expected %b", act_out(), exp_out());
        end
        clock_step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs2D = 7; hz.Rs1D = 3;
        #1;
        n_vec++;
        if ({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD} !== 4'b1110) begin
            n_err++;
            $display("FAIL load_use: got %b expected 1110",
                     {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD});
        end
        hz.RdE = 0; hz.Rs2D = 0;
        #1;
        n_vec++;
        if ({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD} !== 4'b0000) begin
            n_err++;
            $display("FAIL load_use_x0: got %b expected 0000",
                     {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD});
        end
        hz.RdE = 4; hz.Rs1D = 4; hz.PCSrcE = 1;
        #1;
        n_vec++;
        if ({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE} !== 4'b1111) begin
            n_err++;
            $display("FAIL load_use_branch: got %b expected 1111",
                     {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE});
        end
        clock_step();
    endtask

    task automatic test_miss();
        clear_inputs();
        do_reset();
        hz.MemAccessM = 1; hz.PCSrcE = 1;
        for (int c = 0; c < 6; c++) begin
            hz.CacheReadyM = (c == 4);
            if (c == 5) hz.MemAccessM = 0;
            #1;
            n_vec++;
            if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW} !==
                ((c < 4) ? 5'b11111 : 5'b00000)) begin
                n_err++;
                $display("FAIL miss_stall c%0d: got %b expected %b", c,
                         {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW},
                         (c < 4) ? 5'b11111 : 5'b00000);
            end
            n_vec++;
            if ({hz.FlushD, hz.FlushE} !== ((c < 4) ? 2'b00 : 2'b11)) begin
                n_err++;
                $display("FAIL miss_branch c%0d: got %b expected %b", c,
                         {hz.FlushD, hz.FlushE}, (c < 4) ? 2'b00 : 2'b11);
            end
            clock_step();
        end
`ifdef HAZARD_PERF_EN
        n_vec++;
        if (miss_count !== 1 || stall_cycles !== 4) begin
            n_err++;
            $display("FAIL miss_counters: got miss=%0d stall=%0d expected 1/4",
                     miss_count, stall_cycles);
        end
`endif
    endtask

    task automatic test_reset_mid_miss();
        clear_inputs();
        do_reset();
        hz.MemAccessM = 1;
        #1;
        clock_step();
        clock_step();
        // Dropping MemAccessM separates RUN (no stall) from MISS (stall) while in reset.
        rst_n = 1'b0;
        hz.MemAccessM = 0;
        m_miss = 1'b0;
        m_stall_cnt = 0; m_lu_cnt = 0; m_miss_cnt = 0;
        #1;
        n_vec++;
        if (hz.StallF !== 1'b0 || hz.FlushW !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_miss_state: got stall=%b flushw=%b expected 0/0",
                     hz.StallF, hz.FlushW);
        end
`ifdef HAZARD_PERF_EN
        n_vec++;
        if ({stall_cycles, load_use_count, miss_count} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_miss_counters: got %0d/%0d/%0d expected 0/0/0",
                     stall_cycles, load_use_count, miss_count);
        end
`endif
        hz.MemAccessM = 1;
        #1;
        n_vec++;
        if (hz.StallF !== 1'b1) begin
            n_err++;
            $display("FAIL rst_missnow: got %b expected 1", hz.StallF);
        end
        rst_n = 1'b1;
        #1;
        clock_step();
        hz.MemAccessM = 0;
        #1;
        n_vec++;
        if (act_out() !== exp_out() || hz.StallM !== 1'b1) begin
            n_err++;
            $display("FAIL rst_reenter_miss: got %b expected %b", act_out(), exp_out());
        end
`ifdef HAZARD_PERF_EN
        n_vec++;
        if (miss_count !== 1) begin
            n_err++;
            $display("FAIL rst_reenter_count: got %0d expected 1", miss_count);
        end
`endif
        hz.CacheReadyM = 1;
        #1;
        clock_step();
    endtask

    task automatic test_random();
        clear_inputs();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hz.Rs1D = AW'($urandom_range(0, 3)); hz.Rs2D = AW'($urandom_range(0, 3));
            hz.Rs1E = AW'($urandom_range(0, 3)); hz.Rs2E = AW'($urandom_range(0, 3));
            hz.RdE  = AW'($urandom_range(0, 3)); hz.RdM  = AW'($urandom_range(0, 3));
            hz.RdW  = AW'($urandom_range(0, 3));
            hz.RegWriteM   = 1'($urandom_range(0, 1));
            hz.RegWriteW   = 1'($urandom_range(0, 1));
            hz.ResultSrcE0 = 1'($urandom_range(0, 1));
            hz.PCSrcE      = ($urandom_range(0, 3) == 0);
            hz.MemAccessM  = ($urandom_range(0, 2) == 0);
            hz.CacheHitM   = 1'($urandom_range(0, 1));
            hz.CacheReadyM = ($urandom_range(0, 2) == 0);
            #1;
            n_vec++;
            if (act_out() !== exp_out()) begin
                n_err++;
                $display("FAIL random i%0d: got %b expected %b", i, act_out(), exp_out());
            end
            clock_step();
        end
`ifdef HAZARD_PERF_EN
        n_vec++;
        if (stall_cycles !== CW'(m_stall_cnt) || load_use_count !== CW'(m_lu_cnt) ||
            miss_count !== CW'(m_miss_cnt)) begin
            n_err++;
            $display("FAIL random_counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     stall_cycles, load_use_count, miss_count,
                     m_stall_cnt, m_lu_cnt, m_miss_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_miss();
        test_reset_mid_miss();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, the register-index width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, the performance-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, input, REG_ADDR_WIDTH each, the stage register indices.
REQ-006 SHALL have ports RegWriteM, RegWriteW, input, 1 each, the writeback enables in M and W.
REQ-007 SHALL have port ResultSrcE0, input, 1, set when the instruction in E is a load.
REQ-008 SHALL have port PCSrcE, input, 1, set when a taken branch or jump resolves in E.
REQ-009 SHALL have ports MemAccessM, CacheHitM, CacheReadyM, input, 1 each: load or store in M; data-cache hit; refill complete.
REQ-010 SHALL have ports ForwardAE, ForwardBE, output, 2 each, the operand-forward selects.
REQ-011 SHALL have ports StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, output, 1 each.

Function
REQ-012 Forward encoding SHALL be 00 register file, 01 ResultW, 10 ALUResultM; 11 SHALL never be driven.
REQ-013 ForwardAE SHALL be 10 if RegWriteM and RdM==Rs1E and RdM!=0; else 01 if RegWriteW and RdW==Rs1E and RdW!=0; else 00. ForwardBE is identical using Rs2E.
REQ-014 The M-stage match SHALL take priority over the W-stage match, and x0 SHALL never be forwarded.
REQ-015 Forward selects SHALL be combinational, with zero-cycle latency from the inputs.
REQ-016 Load-use hazard (lwStall) SHALL be ResultSrcE0 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-017 The FSM SHALL have two states, RUN and MISS.
REQ-018 In RUN, a miss (missNow = MemAccessM and not CacheHitM) SHALL transition to MISS.
REQ-019 In MISS, CacheReadyM SHALL transition to RUN; otherwise the FSM SHALL hold MISS.
REQ-020 memStall SHALL be (RUN and missNow) or (MISS and not CacheReadyM).
REQ-021 During the CacheReadyM cycle, memStall SHALL be 0, so the pipeline advances that edge.
REQ-022 While memStall, the unit SHALL assert StallF/D/E/M=1 and FlushW=1, and hold FlushD=FlushE=0.
REQ-023 Because memStall holds FlushD/FlushE low, a coincident PCSrcE SHALL take effect only once memStall drops.
REQ-024 Without memStall, the unit SHALL drive StallF=StallD=lwStall, StallE=StallM=FlushW=0, FlushD=PCSrcE, and FlushE=lwStall or PCSrcE.
REQ-025 When lwStall and PCSrcE coincide, the unit SHALL assert StallF, StallD, FlushD and FlushE together.

Reset
REQ-026 While rst_n=0, the FSM SHALL be RUN and all counters SHALL be 0, asynchronously.
REQ-027 Outputs SHALL follow REQ-013..025 with state=RUN during reset.
REQ-028 Reset asserted in MISS SHALL abandon the miss; after release the unit SHALL re-evaluate missNow.

Configuration
REQ-029 With HAZARD_PERF_EN defined, the unit SHALL add outputs StallCycles, LoadUseCount and MissCount, each CNT_WIDTH.
REQ-030 StallCycles SHALL count memStall cycles, LoadUseCount lwStall cycles, and MissCount RUN-to-MISS transitions, each saturating at all-ones.
REQ-031 Without HAZARD_PERF_EN, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package hazard_pkg SHALL hold the FSM state enum, the forward-encoding constants FWD_REG/FWD_W/FWD_M, and the width parameters.
REQ-033 Sub-module forward_select SHALL implement REQ-013/014 for one operand and SHALL be instantiated twice.

Verification
REQ-034 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01.
REQ-035 RdM=0, RegWriteM=1, Rs2E=0 -> ForwardBE=00.
REQ-036 ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 and FlushD=0; with RdE=0 -> all four 0.
REQ-037 Hold MemAccessM=1, CacheHitM=0, raise CacheReadyM on cycle 4 -> stall and FlushW high for cycles 0-3, low on cycle 4, state RUN on cycle 5; MissCount=1 and StallCycles=4 (HAZARD_PERF_EN).
REQ-038 PCSrcE=1 during the miss of REQ-037 -> FlushD=FlushE=0 through cycle 3 and =1 on cycle 4.
REQ-039 Pulse rst_n=0 mid-MISS -> state RUN immediately, counters 0, and MISS re-entered after release if missNow persists.
